// File: rtl/candidate_generator_pkg.sv
// Shared types, charset and sizing for the candidate generator.
// CANDIDATE_GENERATOR_DIGITS_EN extends the charset with '0'..'9' after 'z'.
package candidate_generator_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

`ifdef CANDIDATE_GENERATOR_DIGITS_EN
  localparam int unsigned N = 36;
`else
  localparam int unsigned N = 26;
`endif

  localparam int unsigned WORD_W  = 128;
  localparam int unsigned DIGIT_W = 6;

  function automatic logic [7:0] charset(input logic [DIGIT_W-1:0] d);
    if (d < 6'd26) begin
      return 8'h61 + {2'b00, d};
    end
    return 8'h30 + {2'b00, d} - 8'd26;
  endfunction

endpackage

// File: rtl/cand_digit_adder.sv
// One base-N digit: adds a stride or carry-in and reports the wrap as carry-out.
module cand_digit_adder
  import candidate_generator_pkg::*;
(
  input  logic [5:0] digit,
  input  logic [2:0] addend,
  output logic [5:0] sum,
  output logic       carry
);

  logic [5:0] raw;

  // digit < 36 and addend <= 7, so the raw sum never exceeds 6 bits
  always_comb begin
    raw   = digit + {3'b000, addend};
    carry = (raw >= 6'(N));
    sum   = carry ? raw - 6'(N) : raw;
  end

endmodule

// File: rtl/candidate_generator.sv
// Brute-force candidate generator: streams base-N words of growing length.
// Charset size follows CANDIDATE_GENERATOR_DIGITS_EN (see package).
module candidate_generator
  import candidate_generator_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    start_pos,
  input  logic [2:0]    increment,
  input  logic          stop,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [127:0]  out_word,
  output logic [7:0]    out_width,
  output logic          busy,
  output logic          done,
  output logic [31:0]   cand_count
);

  localparam int unsigned LenW = 5;

  state_e state_q, state_d;

  logic [DIGIT_W-1:0] digits_q   [MAX_LEN];
  logic [DIGIT_W-1:0] digits_d   [MAX_LEN];
  logic [DIGIT_W-1:0] sums       [MAX_LEN];
  logic [DIGIT_W-1:0] adv_digits [MAX_LEN];
  logic [MAX_LEN-1:0] carries;

  logic [LenW-1:0]   len_q, len_d, adv_len;
  logic [2:0]        stride_q, stride_d;
  logic [WORD_W-1:0] word_q, word_d, adv_word;
  logic [7:0]        width_q, width_d;
  logic [31:0]       count_q, count_d;

  logic               top_carry, exhausted, transfer;
  logic [DIGIT_W-1:0] first_digit;

  assign transfer    = (state_q == StRun) && out_ready;
  assign first_digit = (start_pos < 8'(N)) ? start_pos[DIGIT_W-1:0] : '0;

  // Ripple chain; each stage reads its neighbour's carry directly.
  for (genvar k = 0; k < MAX_LEN; k++) begin : g_digit
    logic [2:0] addend;
    logic       carry_out;
    if (k == 0) begin : g_first
      assign addend = stride_q;
    end else begin : g_rest
      assign addend = {2'b00, g_digit[k-1].carry_out};
    end
    cand_digit_adder u_adder (
      .digit  (digits_q[k]),
      .addend (addend),
      .sum    (sums[k]),
      .carry  (carry_out)
    );
    assign carries[k] = carry_out;
  end

  always_comb begin
    top_carry = 1'b0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (len_q == LenW'(k + 1)) top_carry = carries[k];
    end
    exhausted = top_carry && (len_q == LenW'(MAX_LEN));
    adv_len   = (top_carry && !exhausted) ? len_q + LenW'(1) : len_q;
    adv_word  = '0;
    // Digits above the current length stay zero, so a new top digit starts at charset[0].
    for (int k = 0; k < MAX_LEN; k++) begin
      adv_digits[k] = (LenW'(k) < len_q) ? sums[k] : '0;
      if (LenW'(k) < adv_len) adv_word[8*k +: 8] = charset(adv_digits[k]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      for (int k = 0; k < MAX_LEN; k++) digits_q[k] <= '0;
      len_q    <= LenW'(1);
      stride_q <= 3'd1;
      word_q   <= '0;
      width_q  <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      len_q    <= len_d;
      stride_q <= stride_d;
      word_q   <= word_d;
      width_q  <= width_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    len_d    = len_q;
    stride_d = stride_q;
    word_d   = word_q;
    width_d  = width_q;
    count_d  = count_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          for (int k = 0; k < MAX_LEN; k++) digits_d[k] = '0;
          digits_d[0] = first_digit;
          len_d       = LenW'(1);
          stride_d    = (increment == 3'd0) ? 3'd1 : increment;
          count_d     = '0;
          word_d      = {{(WORD_W-8){1'b0}}, charset(first_digit)};
          width_d     = 8'd8;
        end
      end
      StRun: begin
        if (transfer) count_d = count_q + 32'd1;
        // stop wins over advancing, but a coincident transfer is still counted
        if (stop) begin
          state_d = StIdle;
        end else if (transfer) begin
          if (exhausted) begin
            state_d = StDone;
          end else begin
            digits_d = adv_digits;
            len_d    = adv_len;
            word_d   = adv_word;
            width_d  = {adv_len, 3'b000};
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StRun: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  assign out_word   = word_q;
  assign out_width  = width_q;
  assign cand_count = count_q;

endmodule

// File: tb/tb_candidate_generator.sv
// Randomized bench for candidate_generator against a base-N integer model.
// Honours CANDIDATE_GENERATOR_DIGITS_EN for the charset size.
module tb_candidate_generator;

  localparam int MaxLen = 3;
`ifdef CANDIDATE_GENERATOR_DIGITS_EN
  localparam int NChars = 36;
`else
  localparam int NChars = 26;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start, stop, out_ready;
  logic [7:0]   start_pos;
  logic [2:0]   increment;
  logic         out_valid, busy, done;
  logic [127:0] out_word;
  logic [7:0]   out_width;
  logic [31:0]  cand_count;

  candidate_generator #(.MAX_LEN(MaxLen)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .start_pos  (start_pos),
    .increment  (increment),
    .stop       (stop),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_word   (out_word),
    .out_width  (out_width),
    .busy       (busy),
    .done       (done),
    .cand_count (cand_count)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the candidate is an integer in base NChars with m_len digits.
  longint       m_val;
  int           m_len, m_stride;
  bit           m_run, m_done;
  logic [127:0] m_word;
  int           m_width;
  logic [31:0]  m_count;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] char_of(input int d);
    return (d < 26) ? 8'(32'h61 + d) : 8'(32'h30 + d - 26);
  endfunction

  function automatic longint npow(input int e);
    longint r = 1;
    for (int i = 0; i < e; i++) r = r * NChars;
    return r;
  endfunction

  task automatic present();
    m_word = '0;
    for (int k = 0; k < m_len; k++) m_word[8*k +: 8] = char_of(int'((m_val / npow(k)) % NChars));
    m_width = 8 * m_len;
  endtask

  task automatic model_edge();
    if (m_run) begin
      if (out_ready) m_count++;
      if (stop) begin
        m_run = 1'b0;
      end else if (out_ready) begin
        m_val += m_stride;
        if (m_val >= npow(m_len)) begin
          m_val -= npow(m_len);
          if (m_len < MaxLen) begin
            m_len++;
            present();
          end else begin
            m_run  = 1'b0;
            m_done = 1'b1;
          end
        end else begin
          present();
        end
      end
    end else if (start) begin
      m_val    = (int'(start_pos) < NChars) ? longint'(start_pos) : 0;
      m_len    = 1;
      m_stride = (increment == 3'd0) ? 1 : int'(increment);
      m_count  = '0;
      m_run    = 1'b1;
      m_done   = 1'b0;
      present();
    end
  endtask

  task automatic step();
    @(negedge clock);
    check_eq("out_valid",  128'(out_valid),  128'(m_run));
    check_eq("busy",       128'(busy),       128'(m_run));
    check_eq("done",       128'(done),       128'(m_done));
    check_eq("out_word",   out_word,         m_word);
    check_eq("out_width",  128'(out_width),  128'(m_width));
    check_eq("cand_count", 128'(cand_count), 128'(m_count));
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_eq("rst_valid", 128'(out_valid),  128'(0));
    check_eq("rst_busy",  128'(busy),       128'(0));
    check_eq("rst_done",  128'(done),       128'(0));
    check_eq("rst_word",  out_word,         128'(0));
    check_eq("rst_width", 128'(out_width),  128'(0));
    check_eq("rst_count", 128'(cand_count), 128'(0));
    m_run = 1'b0; m_done = 1'b0; m_word = '0; m_width = 0; m_count = '0;
    m_val = 0; m_len = 1; m_stride = 1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic go(input int pos, input int inc);
    start     = 1'b1;
    start_pos = 8'(pos);
    increment = 3'(inc);
    step();
    start = 1'b0;
  endtask

  initial begin
    longint total;
    int     cyc;
    start = 1'b0; stop = 1'b0; out_ready = 1'b0; start_pos = '0; increment = '0;
    #2;
    do_reset();
    repeat (2) step();

    // Full first alphabet plus the length growth
    out_ready = 1'b1;
    go(0, 1);
    repeat (27) step();
    check_eq("count_after_27", 128'(cand_count), 128'(27));
    stop = 1'b1; step(); stop = 1'b0;

    // Stride 3 from 'y' carries into a second digit
    go(24, 3);
    repeat (3) step();
    stop = 1'b1; step(); stop = 1'b0;

    // Back-pressure holds the first candidate
    out_ready = 1'b0;
    go(0, 1);
    repeat (5) step();
    check_eq("stall_count", 128'(cand_count), 128'(0));
    out_ready = 1'b1;
    step();
    check_eq("after_stall", 128'(out_word[7:0]), 128'(char_of(1)));

    // Stop coincident with the transfer of 'c'
    stop = 1'b1; step(); stop = 1'b0;
    go(0, 1);
    repeat (2) step();
    check_eq("at_c", 128'(out_word[7:0]), 128'(char_of(2)));
    stop = 1'b1; step(); stop = 1'b0;
    check_eq("stop_count", 128'(cand_count), 128'(3));
    check_eq("stop_idle",  128'(out_valid),  128'(0));
    go(5, 1);
    check_eq("restart_pos", 128'(out_word[7:0]), 128'(char_of(5)));

    // start ignored in RUN; start beats stop in IDLE; out-of-range pos and zero stride
    start = 1'b1; start_pos = 8'd10; step(); start = 1'b0;
    step();
    stop = 1'b1; step();
    start = 1'b1; start_pos = 8'd3; increment = 3'd2; step();
    start = 1'b0; stop = 1'b0;
    repeat (3) step();
    stop = 1'b1; step(); stop = 1'b0;
    go(200, 0);
    repeat (4) step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom % 16) == 0;
      stop      = ($urandom % 40) == 0;
      out_ready = ($urandom % 4) != 0;
      start_pos = ($urandom % 2) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, NChars - 1));
      increment = 3'($urandom);
      step();
    end
    start = 1'b0; stop = 1'b0;
    stop = 1'b1; step(); stop = 1'b0;

    // Exhaust the space at MaxLen
    out_ready = 1'b1;
    go(0, 1);
    cyc = 0;
    while (!m_done && cyc < 60000) begin
      step();
      cyc++;
    end
    total = npow(1) + npow(2) + npow(3);
    check_eq("exhaust_done",  128'(done),       128'(1));
    check_eq("exhaust_valid", 128'(out_valid),  128'(0));
    check_eq("exhaust_count", 128'(cand_count), 128'(total));
    repeat (3) step();
    go(7, 2);
    repeat (5) step();

    // Asynchronous reset in the middle of a run, then a rerun over the 'z' boundary
    #2;
    do_reset();
    go(24, 1);
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
